// File: rtl/pkt134_to_gmii_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pkt134_to_gmii_tx
//  Description : Store-and-forward 134b packet bus to 8-bit GMII transmitter.
//                Adds preamble/SFD, pads runts to 60 bytes, appends CRC-32
//                FCS and enforces the inter-frame gap.
//  Revision    : 1.0  initial release
// ============================================================================
module pkt134_to_gmii_tx #(
    parameter int FIFO_AW       = 7,
    parameter int MAX_PKT_FLITS = 96,
    parameter int IFG_BYTES     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pktData_valid,
    input  logic [133:0] pktData,
    output logic [7:0]   gmii_txd,
    output logic         gmii_tx_en,
    output logic         gmii_tx_er,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  err_cnt
);

    localparam logic [FIFO_AW:0] c_depth     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] c_ptr_one   = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] c_rsv_flits = (FIFO_AW+1)'(MAX_PKT_FLITS);
    localparam logic [7:0]       c_ifg_last  = 8'(IFG_BYTES - 1);
    localparam logic [31:0]      c_crc_poly  = 32'hEDB88320;
    localparam logic [10:0]      c_min_last  = 11'd59;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG
    } state_t;

    // FIFO entry: {tail, valid_bytes-1, data}
    logic [132:0]       r_mem [0:(1<<FIFO_AW)-1];

    logic [FIFO_AW:0]   r_wr_ptr, r_head_ptr, r_rd_ptr, r_pkt_cnt;
    logic               r_in_pkt;
    logic [15:0]        r_drop_cnt, r_err_cnt;
    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt;
    logic [3:0]         r_byte_idx;
    logic [10:0]        r_len;
    logic [31:0]        r_crc;

    logic               w_is_head, w_is_tail, w_admit, w_push, w_pkt_inc;
    logic [FIFO_AW:0]   w_wr_base, w_used, w_free;
    logic [FIFO_AW-1:0] w_push_addr;
    logic               w_pop, w_pkt_dec;
    logic [132:0]       w_flit;
    logic [3:0]         w_last_idx;
    logic [31:0]        w_fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        return c;
    endfunction

    assign w_is_head  = pktData[132];
    assign w_is_tail  = pktData[133];
    // A head arriving mid-packet rewinds to the abandoned packet's start
    assign w_wr_base  = r_in_pkt ? r_head_ptr : r_wr_ptr;
    assign w_used     = w_wr_base - r_rd_ptr;
    assign w_free     = c_depth - w_used;
    assign w_admit    = (w_free >= c_rsv_flits);

    assign w_flit     = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_last_idx = w_flit[132] ? w_flit[131:128] : 4'hF;
    assign w_fcs      = ~r_crc;

    assign gmii_tx_er = 1'b0;
    assign drop_cnt   = r_drop_cnt;
    assign err_cnt    = r_err_cnt;

    // Decide whether the incoming flit is written and where
    always_comb begin
        w_push      = 1'b0;
        w_push_addr = r_wr_ptr[FIFO_AW-1:0];
        w_pkt_inc   = 1'b0;
        if (pktData_valid) begin
            if (w_is_head) begin
                if (w_admit) begin
                    w_push      = 1'b1;
                    w_push_addr = w_wr_base[FIFO_AW-1:0];
                    w_pkt_inc   = w_is_tail;
                end
            end else if (r_in_pkt) begin
                w_push    = 1'b1;
                w_pkt_inc = w_is_tail;
            end
        end
    end

    // Flit storage (no reset needed; validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[w_push_addr] <= {w_is_tail, pktData[131:0]};
    end

    // Writer state: pointers, packet tracking, drop/error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_head_ptr <= '0;
            r_in_pkt   <= 1'b0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (pktData_valid) begin
            if (w_is_head) begin
                if (r_in_pkt && r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
                if (w_admit) begin
                    r_head_ptr <= w_wr_base;
                    r_wr_ptr   <= w_wr_base + c_ptr_one;
                    r_in_pkt   <= !w_is_tail;
                end else begin
                    // Non-admitted flits fall through to the silent-discard path
                    r_wr_ptr <= w_wr_base;
                    r_in_pkt <= 1'b0;
                    if (r_drop_cnt != 16'hFFFF)
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (r_in_pkt) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (w_is_tail)
                    r_in_pkt <= 1'b0;
            end
        end
    end

    // Count of complete packets stored and not yet fully read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pkt_cnt <= '0;
        else
            r_pkt_cnt <= r_pkt_cnt + (FIFO_AW+1)'(w_pkt_inc) - (FIFO_AW+1)'(w_pkt_dec);
    end

    // Transmit FSM next state and GMII outputs
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_pkt_dec   = 1'b0;
        gmii_tx_en  = 1'b0;
        gmii_txd    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (r_pkt_cnt != '0)
                    w_state_nxt = ST_PRE;
            end
            ST_PRE: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = 8'h55;
                if (r_cnt == 8'd6)
                    w_state_nxt = ST_SFD;
            end
            ST_SFD: begin
                gmii_tx_en  = 1'b1;
                gmii_txd    = 8'hD5;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = w_flit[{~r_byte_idx, 3'b000} +: 8];
                if (r_byte_idx == w_last_idx) begin
                    w_pop = 1'b1;
                    if (w_flit[132]) begin
                        w_pkt_dec   = 1'b1;
                        w_state_nxt = (r_len < c_min_last) ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                gmii_tx_en = 1'b1;
                if (r_len == c_min_last)
                    w_state_nxt = ST_FCS;
            end
            ST_FCS: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt == 8'd3)
                    w_state_nxt = ST_IFG;
            end
            ST_IFG: begin
                // Going straight to PRE keeps the gap at exactly IFG_BYTES
                if (r_cnt == c_ifg_last)
                    w_state_nxt = (r_pkt_cnt != '0) ? ST_PRE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transmit FSM registers: state, per-state counter, byte position, CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_byte_idx <= '0;
            r_len      <= '0;
            r_crc      <= 32'hFFFFFFFF;
            r_rd_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
            if (r_state == ST_SFD) begin
                r_crc      <= 32'hFFFFFFFF;
                r_len      <= '0;
                r_byte_idx <= '0;
            end
            if (r_state == ST_DATA || r_state == ST_PAD) begin
                r_crc <= crc_byte(r_crc, gmii_txd);
                r_len <= r_len + 11'd1;
            end
            if (r_state == ST_DATA)
                r_byte_idx <= w_pop ? 4'd0 : r_byte_idx + 4'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

endmodule
`default_nettype wire
